// File: rtl/serial_addsub_hex.sv
// serial_addsub_hex: W-bit operand registers A/B loaded from switches, a
// bit-serial adder/subtractor (one bit per clock) under a Start/Busy/Done
// handshake, registered result with carry and signed-overflow flags, optional
// accumulate into A, and active-low 7-segment hex displays for A, B and S.
// Optional feature macro: SERIAL_ADDSUB_SAT_EN (clamp S to the signed limit
// on overflow). With the macro undefined the result wraps modulo 2^W.
module serial_addsub_hex #(
    parameter int W = 8,
    parameter int D = W / 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [W-1:0]     Din,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Start,
    input  logic             Sub,
    input  logic             Acc,
    output logic             Busy,
    output logic             Done,
    output logic [W-1:0]     S,
    output logic             Cout,
    output logic             Ovf,
    output logic [7*D-1:0]   HEX_A,
    output logic [7*D-1:0]   HEX_B,
    output logic [7*D-1:0]   HEX_S
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   r_sh;
    logic           carry;
    logic           acc_l;
    logic [CW-1:0]  cnt;
    logic           sum_bit;
    logic           carry_out;
    logic           start_go;
    logic           last_bit;
    logic [W-1:0]   full_res;
    logic [W-1:0]   final_res;

    assign start_go = (state == IDLE) && Start;
    assign last_bit = (state == SHIFT) && (cnt == CW'(W - 1));
    assign Busy     = (state == SHIFT);

    // One full-adder slice; full_res is what the result register holds after this edge
    always_comb begin
        sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
        carry_out = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        full_res  = {sum_bit, r_sh[W-1:1]};
    end

    // Value committed to S (and to A on accumulate); the clamp keys off A's sign
    // because A is frozen for the whole operation
    always_comb begin
        final_res = full_res;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (carry ^ carry_out) begin
            final_res = a_reg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave IDLE on Start, return after the W-th shift
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (Start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand registers, serial datapath and result registers. Sub only matters
    // at load time (inverted B and carry-in of 1), so it is not kept separately.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            a_reg <= '0;
            b_reg <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            acc_l <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (start_go) begin
                a_sh  <= a_reg;
                b_sh  <= b_reg ^ {W{Sub}};
                carry <= Sub;
                acc_l <= Acc;
                cnt   <= '0;
            end else if (state == IDLE) begin
                if (LoadA) a_reg <= Din;
                if (LoadB) b_reg <= Din;
            end else begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                r_sh  <= full_res;
                carry <= carry_out;
                cnt   <= cnt + CW'(1);
                if (last_bit) begin
                    S    <= final_res;
                    Cout <= carry_out;
                    Ovf  <= carry ^ carry_out;
                    Done <= 1'b1;
                    if (acc_l) a_reg <= final_res;
                end
            end
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        unique case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Displays decode only the committed registers, so partial sums never show
    for (genvar i = 0; i < D; i++) begin : g_hex
        assign HEX_A[7*i +: 7] = hex_glyph(a_reg[4*i +: 4]);
        assign HEX_B[7*i +: 7] = hex_glyph(b_reg[4*i +: 4]);
        assign HEX_S[7*i +: 7] = hex_glyph(S[4*i +: 4]);
    end

endmodule

// File: tb/tb_serial_addsub_hex.sv
// Scoreboard bench for serial_addsub_hex (W=8): stimulus pushes expected
// results computed with plain signed/unsigned arithmetic; a monitor pops and
// compares whenever Done is presented.
module tb_serial_addsub_hex;

    localparam int W = 8;
    localparam int D = W / 4;
    localparam logic [16*7-1:0] GLYPHS = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic [W-1:0] a;
    } exp_t;

    logic             Clock;
    logic             Resetn;
    logic [W-1:0]     Din;
    logic             LoadA;
    logic             LoadB;
    logic             Start;
    logic             Sub;
    logic             Acc;
    logic             Busy;
    logic             Done;
    logic [W-1:0]     S;
    logic             Cout;
    logic             Ovf;
    logic [7*D-1:0]   HEX_A;
    logic [7*D-1:0]   HEX_B;
    logic [7*D-1:0]   HEX_S;

    int           checks = 0;
    int           passes = 0;
    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;

    serial_addsub_hex #(.W(W)) dut (
        .Clock(Clock), .Resetn(Resetn), .Din(Din), .LoadA(LoadA), .LoadB(LoadB),
        .Start(Start), .Sub(Sub), .Acc(Acc), .Busy(Busy), .Done(Done), .S(S),
        .Cout(Cout), .Ovf(Ovf), .HEX_A(HEX_A), .HEX_B(HEX_B), .HEX_S(HEX_S)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7*D-1:0] hex_exp(input logic [W-1:0] v);
        logic [7*D-1:0] h;
        for (int i = 0; i < D; i++) h[7*i +: 7] = GLYPHS[7*int'(v[4*i +: 4]) +: 7];
        return h;
    endfunction

    // Reference: exact signed result decides overflow, W+1-bit unsigned sum gives carry
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic acc);
        exp_t    e;
        logic [W:0] raw;
        longint  ia, ib, ex;
        ia = longint'($signed(a));
        ib = longint'($signed(b));
        ex = sub ? ia - ib : ia + ib;
        raw = sub ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b});
        e.s    = raw[W-1:0];
        e.cout = raw[W];
        e.ovf  = (ex > (longint'(1) <<< (W-1)) - 1) || (ex < -(longint'(1) <<< (W-1)));
`ifdef SERIAL_ADDSUB_SAT_EN
        if (e.ovf) e.s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        e.a = acc ? e.s : a;
        return e;
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation
    always @(negedge Clock) begin
        if (Resetn && Done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 64'(1), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                checkOutput("S",     64'(S),     64'(mon_e.s));
                checkOutput("Cout",  64'(Cout),  64'(mon_e.cout));
                checkOutput("Ovf",   64'(Ovf),   64'(mon_e.ovf));
                checkOutput("HEX_S", 64'(HEX_S), 64'(hex_exp(mon_e.s)));
                checkOutput("HEX_A", 64'(HEX_A), 64'(hex_exp(mon_e.a)));
                checkOutput("HEX_B", 64'(HEX_B), 64'(hex_exp(mb)));
            end
        end
    end

    task automatic load(input logic la, input logic lb, input logic [W-1:0] v);
        @(negedge Clock);
        Din = v; LoadA = la; LoadB = lb;
        @(negedge Clock);
        LoadA = 1'b0; LoadB = 1'b0;
        if (la) ma = v;
        if (lb) mb = v;
    endtask

    // One operation; interfere pokes LoadA/Start while busy, collide loads on the Start cycle
    task automatic applyStimulus(input logic sub, input logic acc,
                                 input logic interfere, input logic collide);
        exp_t e;
        int   n;
        @(negedge Clock);
        Sub = sub; Acc = acc; Start = 1'b1;
        if (collide) begin
            Din = W'($urandom); LoadA = 1'b1; LoadB = 1'b1;
        end
        e = model(ma, mb, sub, acc);
        sb.push_back(e);
        ma = e.a;
        @(negedge Clock);
        Start = 1'b0; LoadA = 1'b0; LoadB = 1'b0;
        n = 1;
        checkOutput("busy_after_start", 64'(Busy), 64'(1));
        if (interfere) begin
            Din = 8'hAA; LoadA = 1'b1;
            @(negedge Clock); n++;
            LoadA = 1'b0; Start = 1'b1; Sub = ~sub;
            @(negedge Clock); n++;
            Start = 1'b0;
        end
        while (!Done && n < W + 8) begin
            @(negedge Clock); n++;
        end
        if (Done) checkOutput("done_latency", 64'(n), 64'(W + 1));
        else      checkOutput("done_timeout", 64'(0), 64'(1));
        @(negedge Clock);
        checkOutput("done_one_cycle", 64'(Done), 64'(0));
        checkOutput("idle_after_done", 64'(Busy), 64'(0));
    endtask

    initial begin
        logic saw_done;
        Din = '0; LoadA = 0; LoadB = 0; Start = 0; Sub = 0; Acc = 0;
        Resetn = 1'b0;
        #12;
        checkOutput("rst_busy", 64'(Busy), 64'(0));
        checkOutput("rst_done", 64'(Done), 64'(0));
        checkOutput("rst_S", 64'(S), 64'(0));
        checkOutput("rst_flags", 64'({Cout, Ovf}), 64'(0));
        checkOutput("rst_hex", 64'({HEX_A, HEX_B, HEX_S}), 64'({3*D{7'b1000000}}));
        @(negedge Clock);
        Resetn = 1'b1;

        // Add with signed overflow, with explicit display glyphs "91"
        load(1, 0, 8'h3C); load(0, 1, 8'h55);
        applyStimulus(0, 0, 0, 0);
        checkOutput("hex_s_91", 64'(HEX_S), 64'({7'b0010000, 7'b1111001}));
        // Carry-out, subtract with and without borrow
        load(1, 0, 8'hFF); load(0, 1, 8'h01); applyStimulus(0, 0, 0, 0);
        load(1, 0, 8'h10); load(0, 1, 8'h20); applyStimulus(1, 0, 0, 0);
        load(1, 0, 8'h20); load(0, 1, 8'h10); applyStimulus(1, 0, 0, 0);
        // Accumulate three times
        load(1, 0, 8'h05); load(0, 1, 8'h03);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("hex_a_0E", 64'(HEX_A), 64'({7'b1000000, 7'b0000110}));
        checkOutput("hex_b_03", 64'(HEX_B), 64'({7'b1000000, 7'b0110000}));
        // Saturation boundary cases
        load(1, 0, 8'h7F); load(0, 1, 8'h01); applyStimulus(0, 0, 0, 0);
        load(1, 0, 8'h80); load(0, 1, 8'h01); applyStimulus(1, 0, 0, 0);
        // Both loads together, then Start colliding with loads, then busy interference
        load(1, 1, 8'h42); applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        load(1, 0, 8'h12); load(0, 1, 8'h34);
        applyStimulus(0, 0, 1, 0);
        repeat (W + 2) @(negedge Clock);
        checkOutput("no_restart", 64'(sb.size()), 64'(0));

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            load(1, 0, W'($urandom));
            load(0, 1, W'($urandom));
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        // Reset during the 4th shift cycle
        load(1, 0, 8'h11); load(0, 1, 8'h22);
        @(negedge Clock);
        Sub = 0; Acc = 1; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (3) @(posedge Clock);
        #2 Resetn = 1'b0;
        #1;
        ma = '0; mb = '0;
        checkOutput("midrst_busy", 64'(Busy), 64'(0));
        checkOutput("midrst_out", 64'({S, Cout, Ovf, Done}), 64'(0));
        checkOutput("midrst_hex", 64'({HEX_A, HEX_B, HEX_S}), 64'({3*D{7'b1000000}}));
        saw_done = 1'b0;
        repeat (W + 2) begin
            @(negedge Clock);
            if (Done) saw_done = 1'b1;
        end
        Resetn = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            if (Done) saw_done = 1'b1;
        end
        checkOutput("midrst_no_done", 64'(saw_done), 64'(0));
        load(1, 0, 8'h01); load(0, 1, 8'h02); applyStimulus(0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
